// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit, fixed 33-cycle iterative datapath
// Multiply is radix-2 shift-add and divide is restoring, both on operand magnitudes with a sign fix-up.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd,
   input  logic            flush,
   output logic            busy,
   output logic            reg_write,
   output logic [4:0]      write_reg,
   output logic [XLEN-1:0] write_data
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
   logic [4:0]        wreg_q, wreg_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   // Operand signedness: MULH/MULHSU treat A as signed, only MULH treats B as signed; DIV/REM both.
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
      b_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
      a_neg = a_sgn & rs1_data[XLEN-1];
      b_neg = b_sgn & rs2_data[XLEN-1];
      a_mag = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      b_mag = b_neg ? (~rs2_data + 1'b1) : rs2_data;
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     r_shift;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] iter_next, prod;
   logic [XLEN-1:0]   quo, rem, mul_res, div_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      r_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = {1'b0, r_shift} - {2'b00, opb_q};
      if (state_q == S_MUL)
         iter_next = {mul_sum, acc_q[XLEN-1:1]};
      else if (!div_diff[XLEN+1])
         iter_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         iter_next = {r_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      prod    = neg_q ? (~iter_next + 1'b1) : iter_next;
      quo     = iter_next[XLEN-1:0];
      rem     = iter_next[2*XLEN-1:XLEN];
      mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      if (f3_q[1])
         div_res = neg_rem_q ? (~rem + 1'b1) : rem;
      else if (dz_q)
         div_res = '1;
      else
         div_res = neg_q ? (~quo + 1'b1) : quo;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      wreg_d    = wreg_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               f3_d      = funct3;
               rd_d      = rd;
               cnt_d     = '0;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dz_d      = (rs2_data == '0);
               if (funct3[2]) begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  opb_d   = b_mag;
                  state_d = S_DIV;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  opb_d   = a_mag;
                  state_d = S_MUL;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = iter_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
                  wreg_d  = rd_q;
                  wdata_d = (state_q == S_MUL) ? mul_res : div_res;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         wreg_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign reg_write  = (state_q == S_DONE) && (rd_q != 5'd0) && !flush;
   assign write_reg  = wreg_q;
   assign write_data = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] rs1_data = 32'd0;
   logic [31:0] rs2_data = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic        flush = 1'b0;
   logic        busy, reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int total = 0;
   int bad = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
      .busy(busy), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the following posedge is E0, samples land between edges.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
      int pulses = 0;
      int pulse_k = -1;
      logic [31:0] data = '0;
      logic [4:0]  wr = '0;
      logic        busy32 = 1'b0;
      logic        busy33 = 1'b1;
      start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd = r;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k <= 33; k++) begin
         @(negedge clk);
         if (reg_write) begin
            pulses++;
            pulse_k = k;
            data = write_data;
            wr = write_reg;
         end
         if (k == 32) busy32 = busy;
         if (k == 33) busy33 = busy;
      end
      chk({tag, "_pulses"}, pulses, (r != 5'd0) ? 1 : 0);
      chk({tag, "_busy32"}, {31'd0, busy32}, 32'd1);
      chk({tag, "_busy33"}, {31'd0, busy33}, 32'd0);
      if (r != 5'd0) begin
         chk({tag, "_cycle"}, pulse_k, 32);
         chk({tag, "_data"}, data, exp);
         chk({tag, "_reg"}, {27'd0, wr}, {27'd0, r});
      end
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int pulses = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (reg_write) pulses++;
      end
      chk(tag, pulses, 0);
   endtask

   initial begin
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr", {31'd0, reg_write}, 32'd0);
      chk("rst_wreg", {27'd0, write_reg}, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op("mul7x6",   3'b000, 32'd7,        32'd6,        5'd5,  32'd42);
      run_op("mulh_m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000);
      run_op("mulhu_m1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE);
      run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF);
      run_op("div_m7",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD);
      run_op("rem_m7",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF);
      run_op("divu_z",   3'b101, 32'd10,       32'd0,        5'd9,  32'hFFFFFFFF);
      run_op("remu_z",   3'b111, 32'd10,       32'd0,        5'd10, 32'd10);
      run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
      run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0);
      run_op("divu_100", 3'b101, 32'd100,      32'd7,        5'd13, 32'd14);
      run_op("remu_100", 3'b111, 32'd100,      32'd7,        5'd14, 32'd2);
      run_op("mul_rd0",  3'b000, 32'd9,        32'd9,        5'd0,  32'd0);

      // start held high for 40 edges while operands change every cycle
      begin
         int pulses = 0;
         for (int j = 0; j < 80; j++) begin
            start    = (j < 40);
            funct3   = 3'b000;
            rs1_data = 32'd100 + j;
            rs2_data = (j == 0) ? 32'd3 : j;
            rd       = 5'd2;
            @(posedge clk);
            @(negedge clk);
            if (j == 33) chk("hold_busy33", {31'd0, busy}, 32'd0);
            if (j == 34) chk("hold_busy34", {31'd0, busy}, 32'd1);
            if (reg_write) begin
               if (pulses == 0) begin
                  chk("hold_k1", j, 32);
                  chk("hold_d1", write_data, 32'd300);
               end else begin
                  chk("hold_k2", j, 66);
                  chk("hold_d2", write_data, 32'd4556);
               end
               pulses++;
            end
         end
         start = 1'b0;
         chk("hold_pulses", pulses, 2);
      end

      // flush sampled at E10 of a DIV
      start = 1'b1; funct3 = 3'b100; rs1_data = 32'd50; rs2_data = 32'd5; rd = 5'd15;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      watch_quiet("flush_quiet", 40);

      // reset pulse around E5 of a MUL
      start = 1'b1; funct3 = 3'b000; rs1_data = 32'd11; rs2_data = 32'd12; rd = 5'd16;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_wdata", write_data, 32'd0);
      chk("arst_wreg", {27'd0, write_reg}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      watch_quiet("arst_quiet", 40);
      chk("arst_wdata2", write_data, 32'd0);

      run_op("post_rst", 3'b000, 32'd13, 32'd17, 5'd31, 32'd221);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request; sampled only when busy=0.
REQ-005 funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  in  32  operand A (multiplicand/dividend).
REQ-007 rs2_data  in  32  operand B (multiplier/divisor).
REQ-008 rd  in  5  destination register index.
REQ-009 flush  in  1  synchronous abort of the in-flight op.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 reg_write  out  1  one-cycle writeback strobe toward the register file.
REQ-012 write_reg  out  5  destination index; valid only while reg_write=1.
REQ-013 write_data  out  32  result; valid only while reg_write=1.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-015 IDLE: start=1 and flush=0 at an edge latch funct3, rs1_data, rs2_data and rd, clear the iteration counter, and go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-016 start while busy=1 SHALL be ignored; operands SHALL NOT be re-latched.
REQ-017 MUL: radix-2 shift-add over 32 iterations, one per cycle, 64-bit product; operands sign-extended per funct3 (MULH both signed, MULHSU A signed/B unsigned, MULHU/MUL unsigned treatment acceptable for low word).
REQ-018 MUL result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
REQ-019 DIV: restoring division over 32 iterations on magnitudes; quotient negated if signs differ (DIV), remainder takes dividend sign (REM).
REQ-020 After the 32nd iteration edge the FSM SHALL enter DONE; DONE lasts exactly one cycle, then IDLE.
REQ-021 Latency: start sampled at edge E0 -> reg_write=1 during the cycle following E32; busy=1 from after E0 until E33; earliest next accepted start at E34.
REQ-022 Latency SHALL be fixed at 33 cycles for every funct3 and every operand value, including special cases.
REQ-023 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-025 rd=0: op completes with normal timing; reg_write SHALL stay 0 in DONE.
REQ-026 flush=1 at any edge in MUL/DIV/DONE SHALL return to IDLE with no reg_write pulse; flush has priority over start in the same cycle.
REQ-027 write_reg/write_data SHALL update only on entry to DONE and hold afterwards.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, busy=0, reg_write=0, write_reg=0, write_data=0, counter=0.
REQ-029 rst asserted mid-operation SHALL abort it; no writeback for that op after reset release.
REQ-030 First start SHALL be accepted at the first edge with rst=0.

Verification
REQ-031 MUL 7 x 6, rd=5 -> single reg_write pulse at E32 cycle, write_reg=5, write_data=42; busy low after E33.
REQ-032 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 10 / 0 -> 0xFFFFFFFF, REMU 10 / 0 -> 10; DIV 0x80000000 / -1 -> 0x80000000.
REQ-034 start held high for 40 cycles with changing operands -> exactly one op per 34-cycle window, first operands used, no extra pulses.
REQ-035 flush at E10 of a DIV, then rst pulse at E5 of a subsequent MUL -> no reg_write for either; outputs zero after rst; next op correct.
REQ-036 MUL with rd=0 -> busy timing unchanged, reg_write never asserted.
